// File: rtl/jedro_1_dmem_arbiter.sv
//==============================================================================
// Module : jedro_1_dmem_arbiter
// Brief  : Two-requester arbiter for one data-memory port with a latency-matched
//          read-owner pipeline. Define JEDRO_1_DMEM_ARB_FIXED_PRIO_EN for fixed
//          priority (requester 0 always wins) instead of round-robin.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module jedro_1_dmem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [1:0]                req_i,
   input  logic [1:0]                we_i,
   input  logic [2*DATA_WIDTH/8-1:0] be_i,
   input  logic [2*ADDR_WIDTH-1:0]   addr_i,
   input  logic [2*DATA_WIDTH-1:0]   wdata_i,
   output logic [1:0]                gnt_o,
   output logic [1:0]                rvalid_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      mem_en_o,
   output logic [DATA_WIDTH/8-1:0]   mem_we_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   localparam int BW = DATA_WIDTH / 8;

   logic                   any_req;
   logic                   win_id;
   logic                   win_we;
   logic [BW-1:0]          win_be;
   logic                   rd_issue;
   logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [MEM_LATENCY-1:0] pipe_id_q,  pipe_id_d;

`ifdef JEDRO_1_DMEM_ARB_FIXED_PRIO_EN
   always_comb begin
      win_id = ~req_i[0];
   end
`else
   logic last_gnt_q;
   logic last_gnt_d;

   // On contention the requester that did not win most recently is served.
   always_comb begin
      win_id = 1'b0;
      case (req_i)
         2'b01:   win_id = 1'b0;
         2'b10:   win_id = 1'b1;
         2'b11:   win_id = ~last_gnt_q;
         default: win_id = 1'b0;
      endcase
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (any_req) begin
         last_gnt_d = win_id;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end
`endif

   // Nothing may be granted while reset is asserted, even with requests pending.
   assign any_req = (|req_i) & ~rst_i;

   always_comb begin
      win_we      = win_id ? we_i[1] : we_i[0];
      win_be      = win_id ? be_i[2*BW-1:BW] : be_i[BW-1:0];
      mem_addr_o  = win_id ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
      mem_wdata_o = win_id ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
      mem_en_o    = any_req;
      mem_we_o    = (any_req && win_we) ? win_be : '0;
      gnt_o       = any_req ? (win_id ? 2'b10 : 2'b01) : 2'b00;
      rd_issue    = any_req & ~win_we;
   end

   always_comb begin
      pipe_vld_d    = pipe_vld_q;
      pipe_id_d     = pipe_id_q;
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_id_d[i]  = pipe_id_q[i-1];
      end
      pipe_vld_d[0] = rd_issue;
      pipe_id_d[0]  = win_id;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_vld_q <= '0;
         pipe_id_q  <= '0;
      end else begin
         pipe_vld_q <= pipe_vld_d;
         pipe_id_q  <= pipe_id_d;
      end
   end

   // The tail stage lines up with the cycle the memory presents read data.
   always_comb begin
      rvalid_o = 2'b00;
      rdata_o  = '0;
      if (pipe_vld_q[MEM_LATENCY-1]) begin
         rvalid_o = pipe_id_q[MEM_LATENCY-1] ? 2'b10 : 2'b01;
         rdata_o  = mem_rdata_i;
      end
   end

endmodule

`default_nettype wire
